execute_ldst_sequencer: RTL and testbench

//  Sequences one load/store at a time from the execute address/data calculation stage onto the

---
 rtl/execute_ldst_pkg.sv | 31 +++
 rtl/execute_ldst_sequencer_if.sv | 53 +++++
 rtl/execute_ldst_load_align.sv | 43 ++++
 rtl/execute_ldst_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_execute_ldst_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/execute_ldst_pkg.sv
// Shared types and constants for the execute-stage load/store sequencer.
// Imported by the sequencer top and its load alignment helper.
package execute_ldst_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_RESP  = 3'd3,
      ST_DRAIN = 3'd4
   } state_e;

   localparam logic [1:0] ORDER_BYTE    = 2'd0;
   localparam logic [1:0] ORDER_HALF    = 2'd1;
   localparam logic [1:0] ORDER_WORD    = 2'd2;
   localparam logic [1:0] ORDER_ILLEGAL = 2'd3;

   typedef struct packed {
      logic [31:0] data;
      logic [4:0]  destination;
      logic        spr_valid;
      logic [31:0] spr;
      logic        fault;
   } result_t;

   // An access with no enabled byte lanes or an illegal size never reaches memory.
   function automatic logic is_illegal(input logic [3:0] mask, input logic [1:0] order);
      return (mask == 4'h0) || (order == ORDER_ILLEGAL);
   endfunction

endpackage

// File: rtl/execute_ldst_sequencer_if.sv
// Bundles the execute-calc command, DATAIO memory port and writeback result channels.
// slave = the sequencer, master = its surrounding pipeline and memory.
interface execute_ldst_sequencer_if;

   logic        prev_valid;
   logic        prev_busy;
   logic        prev_rw;
   logic [31:0] prev_addr;
   logic [31:0] prev_data;
   logic [1:0]  prev_order;
   logic [3:0]  prev_mask;
   logic [1:0]  prev_shift;
   logic        prev_spr_valid;
   logic [31:0] prev_spr;
   logic [4:0]  prev_destination;

   logic        dataio_req;
   logic        dataio_busy;
   logic        dataio_rw;
   logic [31:0] dataio_addr;
   logic [31:0] dataio_wdata;
   logic [1:0]  dataio_order;
   logic [3:0]  dataio_mask;
   logic        dataio_valid;
   logic [31:0] dataio_rdata;

   logic        next_valid;
   logic        next_busy;
   logic [31:0] next_data;
   logic [4:0]  next_destination;
   logic        next_spr_valid;
   logic [31:0] next_spr;
   logic        next_fault;

   modport slave (
      input  prev_valid, prev_rw, prev_addr, prev_data, prev_order, prev_mask,
             prev_shift, prev_spr_valid, prev_spr, prev_destination,
             dataio_busy, dataio_valid, dataio_rdata, next_busy,
      output prev_busy, dataio_req, dataio_rw, dataio_addr, dataio_wdata,
             dataio_order, dataio_mask, next_valid, next_data, next_destination,
             next_spr_valid, next_spr, next_fault
   );

   modport master (
      output prev_valid, prev_rw, prev_addr, prev_data, prev_order, prev_mask,
             prev_shift, prev_spr_valid, prev_spr, prev_destination,
             dataio_busy, dataio_valid, dataio_rdata, next_busy,
      input  prev_busy, dataio_req, dataio_rw, dataio_addr, dataio_wdata,
             dataio_order, dataio_mask, next_valid, next_data, next_destination,
             next_spr_valid, next_spr, next_fault
   );

endinterface

// File: rtl/execute_ldst_load_align.sv
// Right-aligns and zero-extends a raw memory word according to access size and lane.
// Purely combinational.
module execute_ldst_load_align
   import execute_ldst_pkg::*;
(
   input  logic [31:0] raw_word,
   input  logic [1:0]  order,
   input  logic [1:0]  shift,
   output logic [31:0] aligned_word
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Lane select for byte and halfword loads.
   always_comb begin
      byte_s = 8'h00;
      case (shift)
         2'd0:    byte_s = raw_word[7:0];
         2'd1:    byte_s = raw_word[15:8];
         2'd2:    byte_s = raw_word[23:16];
         2'd3:    byte_s = raw_word[31:24];
         default: byte_s = 8'h00;
      endcase
      if (shift[1]) begin
         half_s = raw_word[31:16];
      end else begin
         half_s = raw_word[15:0];
      end
   end

   // Size-dependent zero extension.
   always_comb begin
      aligned_word = 32'h0000_0000;
      case (order)
         ORDER_BYTE: aligned_word = {24'h00_0000, byte_s};
         ORDER_HALF: aligned_word = {16'h0000, half_s};
         ORDER_WORD: aligned_word = raw_word;
         default:    aligned_word = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/execute_ldst_sequencer.sv
// Sequences a single outstanding load/store from execute onto the DATAIO port and
// returns the aligned result (or a fault) plus any pending SPR update to writeback.
module execute_ldst_sequencer
   import execute_ldst_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                           iCLOCK,
   input  logic                           iRESET_SYNC,
   input  logic                           iFLUSH,
   execute_ldst_sequencer_if.slave        bus
);

   localparam int TIMER_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   state_e      state_r;
   state_e      state_nxt_s;
   logic        capture_s;
   logic        load_res_s;
   logic        timer_clr_s;
   logic        timeout_s;
   result_t     res_r;
   result_t     res_nxt_s;
   logic        busy_r;
   logic        req_r;
   logic        next_valid_r;
   logic        rw_r;
   logic [31:0] addr_r;
   logic [31:0] wdata_r;
   logic [1:0]  order_r;
   logic [1:0]  shift_r;
   logic [3:0]  mask_r;
   logic        spr_valid_r;
   logic [31:0] spr_r;
   logic [4:0]  dest_r;
   logic [31:0] aligned_s;

   execute_ldst_load_align u_align (
      .raw_word     (bus.dataio_rdata),
      .order        (order_r),
      .shift        (shift_r),
      .aligned_word (aligned_s)
   );

   // Next-state and result selection; a flush in WAIT still owes memory one response.
   always_comb begin
      state_nxt_s = state_r;
      capture_s   = 1'b0;
      load_res_s  = 1'b0;
      timer_clr_s = 1'b0;
      res_nxt_s   = '0;
      case (state_r)
         ST_IDLE: begin
            if (iFLUSH) begin
               state_nxt_s = ST_IDLE;
            end else if (bus.prev_valid) begin
               capture_s = 1'b1;
               if (is_illegal(bus.prev_mask, bus.prev_order)) begin
                  state_nxt_s           = ST_RESP;
                  load_res_s            = 1'b1;
                  res_nxt_s.data        = 32'h0000_0000;
                  res_nxt_s.destination = bus.prev_destination;
                  res_nxt_s.spr_valid   = bus.prev_spr_valid;
                  res_nxt_s.spr         = bus.prev_spr;
                  res_nxt_s.fault       = 1'b1;
               end else begin
                  state_nxt_s = ST_ISSUE;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (iFLUSH) begin
               state_nxt_s = ST_IDLE;
            end else if (!bus.dataio_busy) begin
               state_nxt_s = ST_WAIT;
               timer_clr_s = 1'b1;
            end else begin
               state_nxt_s = ST_ISSUE;
            end
         end
         ST_WAIT: begin
            res_nxt_s.destination = dest_r;
            res_nxt_s.spr_valid   = spr_valid_r;
            res_nxt_s.spr         = spr_r;
            if (iFLUSH) begin
               // A response or timeout landing with the flush leaves nothing to drain.
               if (bus.dataio_valid || timeout_s) begin
                  state_nxt_s = ST_IDLE;
               end else begin
                  state_nxt_s = ST_DRAIN;
               end
            end else if (bus.dataio_valid) begin
               state_nxt_s     = ST_RESP;
               load_res_s      = 1'b1;
               res_nxt_s.data  = rw_r ? 32'h0000_0000 : aligned_s;
               res_nxt_s.fault = 1'b0;
            end else if (timeout_s) begin
               state_nxt_s     = ST_RESP;
               load_res_s      = 1'b1;
               res_nxt_s.data  = 32'h0000_0000;
               res_nxt_s.fault = 1'b1;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_RESP: begin
            if (iFLUSH || !bus.next_busy) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_RESP;
            end
         end
         ST_DRAIN: begin
            if (bus.dataio_valid || timeout_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_DRAIN;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State, registered handshake outputs, captured command and result.
   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) begin
         state_r      <= ST_IDLE;
         busy_r       <= 1'b0;
         req_r        <= 1'b0;
         next_valid_r <= 1'b0;
         rw_r         <= 1'b0;
         addr_r       <= 32'h0000_0000;
         wdata_r      <= 32'h0000_0000;
         order_r      <= 2'd0;
         shift_r      <= 2'd0;
         mask_r       <= 4'h0;
         spr_valid_r  <= 1'b0;
         spr_r        <= 32'h0000_0000;
         dest_r       <= 5'd0;
         res_r        <= '0;
      end else begin
         state_r      <= state_nxt_s;
         busy_r       <= (state_nxt_s != ST_IDLE);
         req_r        <= (state_nxt_s == ST_ISSUE);
         next_valid_r <= (state_nxt_s == ST_RESP);
         if (capture_s) begin
            rw_r        <= bus.prev_rw;
            addr_r      <= bus.prev_addr;
            wdata_r     <= bus.prev_data;
            order_r     <= bus.prev_order;
            shift_r     <= bus.prev_shift;
            mask_r      <= bus.prev_mask;
            spr_valid_r <= bus.prev_spr_valid;
            spr_r       <= bus.prev_spr;
            dest_r      <= bus.prev_destination;
         end
         if (load_res_s) begin
            res_r <= res_nxt_s;
         end
      end
   end

   generate
      if (TIMEOUT_CYCLES != 0) begin : g_timer
         logic [TIMER_W-1:0] timer_r;

         // Counts cycles spent waiting on memory, including while draining after a flush.
         always_ff @(posedge iCLOCK) begin
            if (iRESET_SYNC) begin
               timer_r <= '0;
            end else if (timer_clr_s) begin
               timer_r <= '0;
            end else if ((state_r == ST_WAIT) || (state_r == ST_DRAIN)) begin
               timer_r <= timer_r + TIMER_W'(1);
            end else begin
               timer_r <= timer_r;
            end
         end

         assign timeout_s = ((state_r == ST_WAIT) || (state_r == ST_DRAIN)) &&
                            (timer_r == TIMER_W'(TIMEOUT_CYCLES - 1));
      end else begin : g_no_timer
         assign timeout_s = 1'b0;
      end
   endgenerate

   assign bus.prev_busy        = busy_r;
   assign bus.dataio_req       = req_r;
   assign bus.dataio_rw        = rw_r;
   assign bus.dataio_addr      = addr_r;
   assign bus.dataio_wdata     = wdata_r;
   assign bus.dataio_order     = order_r;
   assign bus.dataio_mask      = mask_r;
   assign bus.next_valid       = next_valid_r;
   assign bus.next_data        = res_r.data;
   assign bus.next_destination = res_r.destination;
   assign bus.next_spr_valid   = res_r.spr_valid;
   assign bus.next_spr         = res_r.spr;
   assign bus.next_fault       = res_r.fault;

endmodule

// File: tb/tb_execute_ldst_sequencer.sv
// Randomised and directed bench for execute_ldst_sequencer against a transaction-level
// model that tracks the op in flight as a set of flags plus a wait counter.
module tb_execute_ldst_sequencer;

   localparam int TO = 8;

   logic clk;
   logic rst;
   logic flush;
   int   tests_run;
   int   tests_failed;
   bit   chk_en;

   execute_ldst_sequencer_if bus ();

   execute_ldst_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
      .iCLOCK      (clk),
      .iRESET_SYNC (rst),
      .iFLUSH      (flush),
      .bus         (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic        issuing;
      logic        in_flight;
      logic        draining;
      logic        ready;
      logic [31:0] waited;
      logic        rw;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  order;
      logic [3:0]  mask;
      logic [1:0]  shift;
      logic        sprv;
      logic [31:0] spr;
      logic [4:0]  dest;
      logic [31:0] res_data;
      logic        fault;
   } mdl_t;

   mdl_t m;

   function automatic logic [31:0] exp_align(input logic [31:0] w, input logic [1:0] order,
                                             input logic [1:0] shift);
      case (order)
         2'd0:    return (w >> (8 * shift)) & 32'h0000_00FF;
         2'd1:    return (w >> (16 * (shift / 2))) & 32'h0000_FFFF;
         2'd2:    return w;
         default: return 32'h0;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: advances one clock on the inputs seen at the edge.
   always @(posedge clk) begin : model
      mdl_t n;
      logic to;
      n = m;
      to = 1'b0;
      if (rst) begin
         n = '0;
      end else if (m.ready) begin
         if (flush || !bus.next_busy) n.ready = 1'b0;
      end else if (m.issuing) begin
         if (flush) begin
            n.issuing = 1'b0;
         end else if (!bus.dataio_busy) begin
            n.issuing   = 1'b0;
            n.in_flight = 1'b1;
            n.waited    = 32'd0;
         end
      end else if (m.in_flight) begin
         to = (m.waited == TO - 1);
         n.in_flight = 1'b0;
         if (flush) begin
            n.draining = !(bus.dataio_valid || to);
            n.waited   = m.waited + 32'd1;
         end else if (bus.dataio_valid) begin
            n.ready    = 1'b1;
            n.fault    = 1'b0;
            n.res_data = m.rw ? 32'h0 : exp_align(bus.dataio_rdata, m.order, m.shift);
         end else if (to) begin
            n.ready    = 1'b1;
            n.fault    = 1'b1;
            n.res_data = 32'h0;
         end else begin
            n.in_flight = 1'b1;
            n.waited    = m.waited + 32'd1;
         end
      end else if (m.draining) begin
         if (bus.dataio_valid || (m.waited == TO - 1)) n.draining = 1'b0;
         else n.waited = m.waited + 32'd1;
      end else if (!flush && bus.prev_valid) begin
         n.rw    = bus.prev_rw;
         n.addr  = bus.prev_addr;
         n.wdata = bus.prev_data;
         n.order = bus.prev_order;
         n.mask  = bus.prev_mask;
         n.shift = bus.prev_shift;
         n.sprv  = bus.prev_spr_valid;
         n.spr   = bus.prev_spr;
         n.dest  = bus.prev_destination;
         if ((bus.prev_mask == 4'h0) || (bus.prev_order == 2'd3)) begin
            n.ready    = 1'b1;
            n.fault    = 1'b1;
            n.res_data = 32'h0;
         end else begin
            n.issuing = 1'b1;
         end
      end
      m <= n;
   end

   // Compare DUT outputs with the model mid-cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         check("prev_busy", bus.prev_busy, m.issuing | m.in_flight | m.draining | m.ready);
         check("dataio_req", bus.dataio_req, m.issuing);
         check("next_valid", bus.next_valid, m.ready);
         if (m.issuing) begin
            check("dataio_rw", bus.dataio_rw, m.rw);
            check("dataio_addr", bus.dataio_addr, m.addr);
            check("dataio_wdata", bus.dataio_wdata, m.wdata);
            check("dataio_order", bus.dataio_order, m.order);
            check("dataio_mask", bus.dataio_mask, m.mask);
         end
         if (m.ready) begin
            check("next_data", bus.next_data, m.res_data);
            check("next_dest", bus.next_destination, m.dest);
            check("next_spr_valid", bus.next_spr_valid, m.sprv);
            check("next_spr", bus.next_spr, m.spr);
            check("next_fault", bus.next_fault, m.fault);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_inputs();
      flush = 1'b0;
      bus.prev_valid = 1'b0;       bus.prev_rw = 1'b0;
      bus.prev_addr = 32'h0;       bus.prev_data = 32'h0;
      bus.prev_order = 2'd0;       bus.prev_mask = 4'h0;
      bus.prev_shift = 2'd0;       bus.prev_spr_valid = 1'b0;
      bus.prev_spr = 32'h0;        bus.prev_destination = 5'd0;
      bus.dataio_busy = 1'b0;      bus.dataio_valid = 1'b0;
      bus.dataio_rdata = 32'h0;    bus.next_busy = 1'b0;
   endtask

   task automatic send_cmd(input logic rw, input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] order, input logic [3:0] mask,
                           input logic [1:0] shift, input logic sprv,
                           input logic [31:0] spr, input logic [4:0] dest);
      bus.prev_valid = 1'b1;  bus.prev_rw = rw;       bus.prev_addr = addr;
      bus.prev_data = data;   bus.prev_order = order; bus.prev_mask = mask;
      bus.prev_shift = shift; bus.prev_spr_valid = sprv;
      bus.prev_spr = spr;     bus.prev_destination = dest;
      step();
      bus.prev_valid = 1'b0;
   endtask

   initial begin
      int reqcnt;
      tests_run = 0;
      tests_failed = 0;
      chk_en = 1'b0;
      rst = 1'b1;
      idle_inputs();
      step(); step(); step();
      check("rst_busy", bus.prev_busy, 1'b0);
      check("rst_req", bus.dataio_req, 1'b0);
      check("rst_next_valid", bus.next_valid, 1'b0);
      check("rst_next_data", bus.next_data, 32'h0);
      check("rst_fault", bus.next_fault, 1'b0);
      check("rst_addr", bus.dataio_addr, 32'h0);
      rst = 1'b0;
      chk_en = 1'b1;
      step();

      // 1: byte load from lane 3
      send_cmd(1'b0, 32'h0000_1003, 32'h0, 2'd0, 4'b1000, 2'd3, 1'b0, 32'h0, 5'd3);
      check("t1_req", bus.dataio_req, 1'b1);
      step();
      bus.dataio_valid = 1'b1; bus.dataio_rdata = 32'hAABB_CCDD;
      step();
      bus.dataio_valid = 1'b0;
      check("t1_valid", bus.next_valid, 1'b1);
      check("t1_data", bus.next_data, 32'h0000_00AA);
      check("t1_fault", bus.next_fault, 1'b0);
      check("t1_dest", bus.next_destination, 32'd3);
      step();

      // 2: half load with memory stalling three cycles, writeback stalling two
      bus.dataio_busy = 1'b1;
      send_cmd(1'b0, 32'h0000_2002, 32'h0, 2'd1, 4'b1100, 2'd2, 1'b0, 32'h0, 5'd7);
      reqcnt = 0;
      repeat (3) begin
         if (bus.dataio_req) reqcnt++;
         check("t2_addr_hold", bus.dataio_addr, 32'h0000_2002);
         step();
      end
      bus.dataio_busy = 1'b0;
      if (bus.dataio_req) reqcnt++;
      step();
      check("t2_req_cycles", reqcnt, 32'd4);
      check("t2_req_drop", bus.dataio_req, 1'b0);
      bus.dataio_valid = 1'b1; bus.dataio_rdata = 32'h1234_5678; bus.next_busy = 1'b1;
      step();
      bus.dataio_valid = 1'b0;
      check("t2_data", bus.next_data, 32'h0000_1234);
      step();
      check("t2_hold_valid", bus.next_valid, 1'b1);
      check("t2_hold_data", bus.next_data, 32'h0000_1234);
      bus.next_busy = 1'b0;
      step();
      check("t2_release", bus.next_valid, 1'b0);

      // 3: PUSH-style store with SPR update
      send_cmd(1'b1, 32'h0000_0FFC, 32'h1122_3344, 2'd2, 4'hF, 2'd0, 1'b1, 32'h0000_0FFC, 5'd0);
      check("t3_rw", bus.dataio_rw, 1'b1);
      check("t3_wdata", bus.dataio_wdata, 32'h1122_3344);
      step();
      bus.dataio_valid = 1'b1; bus.dataio_rdata = 32'hDEAD_BEEF;
      step();
      bus.dataio_valid = 1'b0;
      check("t3_data", bus.next_data, 32'h0);
      check("t3_spr_valid", bus.next_spr_valid, 1'b1);
      check("t3_spr", bus.next_spr, 32'h0000_0FFC);
      step();

      // 4: zero mask faults without a request
      send_cmd(1'b0, 32'h0000_2001, 32'h0, 2'd1, 4'h0, 2'd1, 1'b0, 32'h0, 5'd9);
      check("t4_req", bus.dataio_req, 1'b0);
      check("t4_valid", bus.next_valid, 1'b1);
      check("t4_fault", bus.next_fault, 1'b1);
      step();

      // 5: timeout after TO wait cycles; a late response is ignored
      send_cmd(1'b0, 32'h0000_4000, 32'h0, 2'd2, 4'hF, 2'd0, 1'b0, 32'h0, 5'd4);
      step();
      repeat (TO) begin
         check("t5_no_valid", bus.next_valid, 1'b0);
         step();
      end
      check("t5_valid", bus.next_valid, 1'b1);
      check("t5_fault", bus.next_fault, 1'b1);
      bus.dataio_valid = 1'b1; bus.dataio_rdata = 32'h5555_5555; bus.next_busy = 1'b1;
      step();
      bus.dataio_valid = 1'b0; bus.next_busy = 1'b0;
      check("t5_late_data", bus.next_data, 32'h0);
      step();
      check("t5_idle", bus.prev_busy, 1'b0);

      // 6: flush in WAIT drains one response, then a fresh load completes
      send_cmd(1'b0, 32'h0000_5000, 32'h0, 2'd2, 4'hF, 2'd0, 1'b0, 32'h0, 5'd5);
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("t6_drain_busy", bus.prev_busy, 1'b1);
      step();
      bus.dataio_valid = 1'b1; bus.dataio_rdata = 32'h9999_9999;
      step();
      bus.dataio_valid = 1'b0;
      check("t6_no_valid", bus.next_valid, 1'b0);
      check("t6_idle", bus.prev_busy, 1'b0);
      send_cmd(1'b0, 32'h0000_3000, 32'h0, 2'd2, 4'hF, 2'd0, 1'b0, 32'h0, 5'd6);
      step();
      bus.dataio_valid = 1'b1; bus.dataio_rdata = 32'hCAFE_F00D;
      step();
      bus.dataio_valid = 1'b0;
      check("t6_valid", bus.next_valid, 1'b1);
      check("t6_data", bus.next_data, 32'hCAFE_F00D);
      step();

      // Flush beats a command in IDLE; reset abandons an op in WAIT
      flush = 1'b1;
      send_cmd(1'b0, 32'h0000_6000, 32'h0, 2'd2, 4'hF, 2'd0, 1'b0, 32'h0, 5'd1);
      flush = 1'b0;
      check("flush_idle", bus.prev_busy, 1'b0);
      send_cmd(1'b0, 32'h0000_7000, 32'h0, 2'd2, 4'hF, 2'd0, 1'b0, 32'h0, 5'd2);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.dataio_valid = 1'b1; bus.dataio_rdata = 32'h1111_1111;
      step();
      bus.dataio_valid = 1'b0;
      check("rst_mid_busy", bus.prev_busy, 1'b0);
      check("rst_mid_valid", bus.next_valid, 1'b0);

      // Random traffic checked cycle by cycle against the model
      for (int i = 0; i < 4000; i++) begin
         rst = ($urandom_range(0, 599) == 0);
         flush = ($urandom_range(0, 19) == 0);
         bus.prev_valid = ($urandom_range(0, 2) != 0);
         bus.prev_rw = 1'($urandom_range(0, 1));
         bus.prev_addr = $urandom;
         bus.prev_data = $urandom;
         bus.prev_order = 2'($urandom_range(0, 3));
         bus.prev_mask = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         bus.prev_shift = 2'($urandom_range(0, 3));
         bus.prev_spr_valid = 1'($urandom_range(0, 1));
         bus.prev_spr = $urandom;
         bus.prev_destination = 5'($urandom_range(0, 31));
         bus.dataio_busy = ($urandom_range(0, 2) == 0);
         bus.dataio_valid = ($urandom_range(0, 4) == 0);
         bus.dataio_rdata = $urandom;
         bus.next_busy = ($urandom_range(0, 2) == 0);
         step();
      end
      idle_inputs();
      rst = 1'b0;
      repeat (2 * TO + 4) step();
      check("final_idle", bus.prev_busy, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
